intp_svc_master: RTL and testbench

- Processor-side initiator paired with the interrupt controller.
- Acts as APB master: programs the controller's per-peripheral priority registers from a packed configuration vector.
- Consumes the controller's interrupt request (valid + peripheral id), models a fixed-length service routine, then returns a one-cycle serviced pulse.
- Sits between the CPU/test sequencer and the interrupt controller.

---
 rtl/intp_svc_master.sv | 228 ++++++++++++++++++++++
 tb/tb_intp_svc_master.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intp_svc_master.sv
// -----------------------------------------------------------------------------
// intp_svc_master
//
// Processor-side initiator paired with the interrupt controller.
//  * APB master: programs the controller's per-peripheral priority registers
//    (addresses 0..NUM_OF_PERIPHERALS-1) from a packed configuration vector.
//  * Interrupt consumer: takes a pending request (valid + id), spends
//    SERVICE_CYCLES cycles "servicing" it, then returns a one-cycle pulse.
//
// Optional feature (macro INTP_SVC_READBACK_EN):
//   When defined, every register write is followed by a read of the same
//   address, and the returned data is compared with the written value.
//   When undefined, sequencing is write-only and cfg_err_o reflects perror_i.
//
// Ports:
//   pclk_i, prst_n_i      clock, asynchronous active-low reset
//   cfg_start_i           pulse: program all priority registers
//   cfg_prio_i            packed priorities, peripheral k at [k*DW +: DW]
//   cfg_busy_o            configuration pending or in progress
//   cfg_done_o            one-cycle pulse after the last register
//   cfg_err_o             sticky APB error (cleared when a start is accepted)
//   paddr_o .. penable_o  APB master request signals
//   prdata_i, pready_i,
//   perror_i              APB completer response
//   intp_valid_i          interrupt pending from the controller
//   intp_to_service_i     id of the peripheral to service
//   intp_serviced_o       one-cycle service-complete pulse
//   svc_id_o              id captured for the current/last service
//   svc_busy_o            high while servicing and acknowledging
//   svc_count_o           completed services, wraps 255->0
// -----------------------------------------------------------------------------
module intp_svc_master #(
  parameter int NUM_OF_PERIPHERALS = 16,
  parameter int ADDR_WIDTH         = 4,
  parameter int DATA_WIDTH         = 4,
  parameter int SERVICE_CYCLES     = 4
) (
  input  logic                                     pclk_i,
  input  logic                                     prst_n_i,
  input  logic                                     cfg_start_i,
  input  logic [NUM_OF_PERIPHERALS*DATA_WIDTH-1:0] cfg_prio_i,
  output logic                                     cfg_busy_o,
  output logic                                     cfg_done_o,
  output logic                                     cfg_err_o,
  output logic [ADDR_WIDTH-1:0]                    paddr_o,
  output logic                                     pwrite_o,
  output logic [DATA_WIDTH-1:0]                    pwdata_o,
  output logic                                     penable_o,
  input  logic [DATA_WIDTH-1:0]                    prdata_i,
  input  logic                                     pready_i,
  input  logic                                     perror_i,
  input  logic                                     intp_valid_i,
  input  logic [ADDR_WIDTH-1:0]                    intp_to_service_i,
  output logic                                     intp_serviced_o,
  output logic [ADDR_WIDTH-1:0]                    svc_id_o,
  output logic                                     svc_busy_o,
  output logic [7:0]                               svc_count_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_OF_PERIPHERALS - 1);
  localparam logic [7:0]            SVC_LOAD = 8'(SERVICE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_SETUP,
    S_CFG_ACCESS,
    S_CFG_RD_SETUP,
    S_CFG_RD_ACCESS,
    S_CFG_DONE,
    S_SERVICE,
    S_ACK,
    S_DRAIN
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [ADDR_WIDTH-1:0]   next_idx;
  logic [DATA_WIDTH-1:0]   next_prio;
  logic [7:0]              svc_cnt;
  logic                    cfg_pend;
  logic                    cfg_active;

`ifndef INTP_SVC_READBACK_EN
  // Read data is only consumed by the readback feature.
  logic unused_prdata;
  assign unused_prdata = ^prdata_i;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cfg_active = 1'b0;
    svc_busy_o = 1'b0;
    case (state)
      S_CFG_SETUP, S_CFG_ACCESS, S_CFG_RD_SETUP,
      S_CFG_RD_ACCESS, S_CFG_DONE: cfg_active = 1'b1;
      S_SERVICE, S_ACK:            svc_busy_o = 1'b1;
      default: ;
    endcase
  end

  assign cfg_busy_o = cfg_pend | cfg_active;
  assign next_idx   = idx + 1'b1;
  assign next_prio  = cfg_prio_i[int'(next_idx)*DATA_WIDTH +: DATA_WIDTH];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state           <= S_IDLE;
      idx             <= '0;
      svc_cnt         <= '0;
      cfg_pend        <= 1'b0;
      cfg_done_o      <= 1'b0;
      cfg_err_o       <= 1'b0;
      paddr_o         <= '0;
      pwrite_o        <= 1'b0;
      pwdata_o        <= '0;
      penable_o       <= 1'b0;
      intp_serviced_o <= 1'b0;
      svc_id_o        <= '0;
      svc_count_o     <= '0;
    end else begin
      cfg_done_o      <= 1'b0;
      intp_serviced_o <= 1'b0;

      // A start arriving mid-configuration is dropped; otherwise it is
      // remembered until IDLE can act on it.
      if (cfg_start_i && !cfg_active) cfg_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (intp_valid_i) begin
            // Interrupts take precedence over a pending configuration.
            state    <= S_SERVICE;
            svc_id_o <= intp_to_service_i;
            svc_cnt  <= SVC_LOAD;
          end else if (cfg_pend || cfg_start_i) begin
            cfg_pend  <= 1'b0;
            cfg_err_o <= 1'b0;
            idx       <= '0;
            paddr_o   <= '0;
            pwrite_o  <= 1'b1;
            pwdata_o  <= cfg_prio_i[DATA_WIDTH-1:0];
            state     <= S_CFG_SETUP;
          end
        end

        S_CFG_SETUP: begin
          penable_o <= 1'b1;
          state     <= S_CFG_ACCESS;
        end

        S_CFG_ACCESS: begin
          if (pready_i) begin
            penable_o <= 1'b0;
            if (perror_i) cfg_err_o <= 1'b1;
`ifdef INTP_SVC_READBACK_EN
            pwrite_o <= 1'b0;
            state    <= S_CFG_RD_SETUP;
`else
            if (idx == LAST_IDX) begin
              paddr_o  <= '0;
              pwrite_o <= 1'b0;
              pwdata_o <= '0;
              cfg_done_o <= 1'b1;
              state    <= S_CFG_DONE;
            end else begin
              idx      <= next_idx;
              paddr_o  <= next_idx;
              pwdata_o <= next_prio;
              state    <= S_CFG_SETUP;
            end
`endif
          end
        end

`ifdef INTP_SVC_READBACK_EN
        S_CFG_RD_SETUP: begin
          penable_o <= 1'b1;
          state     <= S_CFG_RD_ACCESS;
        end

        S_CFG_RD_ACCESS: begin
          if (pready_i) begin
            penable_o <= 1'b0;
            // pwdata_o still holds the value just written to this address.
            if (perror_i || (prdata_i != pwdata_o)) cfg_err_o <= 1'b1;
            if (idx == LAST_IDX) begin
              paddr_o    <= '0;
              pwdata_o   <= '0;
              cfg_done_o <= 1'b1;
              state      <= S_CFG_DONE;
            end else begin
              idx      <= next_idx;
              paddr_o  <= next_idx;
              pwrite_o <= 1'b1;
              pwdata_o <= next_prio;
              state    <= S_CFG_SETUP;
            end
          end
        end
`endif

        S_CFG_DONE: state <= S_IDLE;

        S_SERVICE: begin
          if (svc_cnt == 8'd0) begin
            intp_serviced_o <= 1'b1;
            svc_count_o     <= svc_count_o + 8'd1;
            state           <= S_ACK;
          end else begin
            svc_cnt <= svc_cnt - 8'd1;
          end
        end

        S_ACK: state <= S_DRAIN;

        // Hold here until the controller has withdrawn the request, so the
        // same request is never serviced twice.
        S_DRAIN: if (!intp_valid_i) state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intp_svc_master.sv
// -----------------------------------------------------------------------------
// tb_intp_svc_master
//
// Scoreboard bench for intp_svc_master. Stimulus pushes the expected APB
// transfers, service pulses and done pulses into a queue; a monitor sampling
// one time unit after each falling edge pops and compares whenever the DUT
// completes one of them. A simple APB completer model supplies ready/error/
// read data with programmable wait states, an error address and a corrupted
// read address. Build with INTP_SVC_READBACK_EN to exercise readback.
// -----------------------------------------------------------------------------
module tb_intp_svc_master;

  localparam int NP = 16;
  localparam int AW = 4;
  localparam int DW = 4;
  localparam int SC = 4;
`ifdef INTP_SVC_READBACK_EN
  localparam int PER_REG = 4;
`else
  localparam int PER_REG = 2;
`endif

  logic              pclk_i = 1'b0;
  logic              prst_n_i = 1'b0;
  logic              cfg_start_i = 1'b0;
  logic [NP*DW-1:0]  cfg_prio_i = '0;
  logic              cfg_busy_o, cfg_done_o, cfg_err_o;
  logic [AW-1:0]     paddr_o;
  logic              pwrite_o, penable_o;
  logic [DW-1:0]     pwdata_o;
  logic [DW-1:0]     prdata_i = '0;
  logic              pready_i = 1'b0;
  logic              perror_i = 1'b0;
  logic              intp_valid_i = 1'b0;
  logic [AW-1:0]     intp_to_service_i = '0;
  logic              intp_serviced_o;
  logic [AW-1:0]     svc_id_o;
  logic              svc_busy_o;
  logic [7:0]        svc_count_o;

  intp_svc_master #(
    .NUM_OF_PERIPHERALS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SERVICE_CYCLES(SC)
  ) dut (
    .pclk_i(pclk_i), .prst_n_i(prst_n_i),
    .cfg_start_i(cfg_start_i), .cfg_prio_i(cfg_prio_i),
    .cfg_busy_o(cfg_busy_o), .cfg_done_o(cfg_done_o), .cfg_err_o(cfg_err_o),
    .paddr_o(paddr_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .penable_o(penable_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .perror_i(perror_i),
    .intp_valid_i(intp_valid_i), .intp_to_service_i(intp_to_service_i),
    .intp_serviced_o(intp_serviced_o), .svc_id_o(svc_id_o),
    .svc_busy_o(svc_busy_o), .svc_count_o(svc_count_o)
  );

  always #5 pclk_i = ~pclk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  typedef enum logic [1:0] {E_WR, E_RD, E_SVC, E_DONE} ekind_t;
  typedef struct {
    ekind_t     kind;
    logic [7:0] a;
    logic [7:0] d;
  } exp_t;
  exp_t q[$];

  task automatic push(input ekind_t k, input int a, input int d);
    exp_t e;
    e.kind = k;
    e.a    = 8'(a);
    e.d    = 8'(d);
    q.push_back(e);
  endtask

  task automatic pop_cmp(input string nm, input ekind_t k, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    if (q.size() == 0) begin
      check({nm, "_unexpected"}, 32'd1, 32'd0);
      return;
    end
    e = q.pop_front();
    check({nm, "_kind"}, 32'(k), 32'(e.kind));
    check({nm, "_a"}, 32'(a), 32'(e.a));
    if (k != E_RD) check({nm, "_d"}, 32'(d), 32'(e.d));
  endtask

  // Priority patterns used by the configuration runs.
  function automatic logic [DW-1:0] prio(input int mode, input int k);
    case (mode)
      0:       return DW'(k + 1);
      1:       return DW'(15 - k);
      default: return DW'(k);
    endcase
  endfunction

  task automatic set_prio(input int mode);
    for (int k = 0; k < NP; k++) cfg_prio_i[k*DW +: DW] = prio(mode, k);
  endtask

  task automatic push_writes(input int mode, input int upto);
    for (int k = 0; k < upto; k++) begin
      push(E_WR, k, prio(mode, k));
`ifdef INTP_SVC_READBACK_EN
      push(E_RD, k, 0);
`endif
    end
  endtask

  task automatic push_cfg(input int mode, input int err);
    push_writes(mode, NP);
    push(E_DONE, 0, err);
  endtask

  // ------------------------------------------------------------ APB completer
  int         wait_n       = 0;
  int         err_addr     = -1;
  int         corrupt_addr = -1;
  int         wcnt         = 0;
  logic [DW-1:0] mem [NP];

  always @(negedge pclk_i) begin
    if (prst_n_i && penable_o) begin
      if (wcnt < wait_n) begin
        pready_i = 1'b0;
        perror_i = 1'b0;
        wcnt++;
      end else begin
        pready_i = 1'b1;
        perror_i = pwrite_o && (int'(paddr_o) == err_addr);
        if (pwrite_o) mem[paddr_o] = pwdata_o;
        prdata_i = mem[paddr_o] ^ ((int'(paddr_o) == corrupt_addr) ? DW'('1) : DW'(0));
      end
    end else begin
      pready_i = 1'b0;
      perror_i = 1'b0;
      wcnt     = 0;
    end
  end

  // ------------------------------------------------------------------ monitor
  logic          prev_pen  = 1'b0;
  logic          prev_rdy  = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  initial begin
    forever begin
      @(negedge pclk_i);
      #1;
      if (!prst_n_i) begin
        prev_pen = 1'b0;
        prev_rdy = 1'b0;
      end else begin
        if (penable_o && prev_pen && !prev_rdy) begin
          check("wait_addr_stable", 32'(paddr_o), 32'(prev_addr));
          check("wait_data_stable", 32'(pwdata_o), 32'(prev_data));
        end
        if (prev_pen && prev_rdy) check("penable_gap", 32'(penable_o), 32'd0);
        if (penable_o && pready_i)
          pop_cmp("xfer", pwrite_o ? E_WR : E_RD, 8'(paddr_o), 8'(pwdata_o));
        if (intp_serviced_o) pop_cmp("svc", E_SVC, 8'(svc_id_o), svc_count_o);
        if (cfg_done_o)      pop_cmp("done", E_DONE, 8'd0, 8'(cfg_err_o));
        prev_pen  = penable_o;
        prev_rdy  = pready_i;
        prev_addr = paddr_o;
        prev_data = pwdata_o;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  task automatic run_cfg(output int cyc);
    cfg_start_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
    cyc = 0;
    while (!cfg_done_o && cyc < 400) begin
      tick();
      cyc++;
    end
    if (!cfg_done_o) check("cfg_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_paddr"},   32'(paddr_o),   32'd0);
    check({tag, "_pwrite"},  32'(pwrite_o),  32'd0);
    check({tag, "_pwdata"},  32'(pwdata_o),  32'd0);
    check({tag, "_penable"}, 32'(penable_o), 32'd0);
    check({tag, "_cfg_busy"}, 32'(cfg_busy_o), 32'd0);
    check({tag, "_cfg_done"}, 32'(cfg_done_o), 32'd0);
    check({tag, "_cfg_err"},  32'(cfg_err_o),  32'd0);
    check({tag, "_serviced"}, 32'(intp_serviced_o), 32'd0);
    check({tag, "_svc_id"},   32'(svc_id_o),   32'd0);
    check({tag, "_svc_busy"}, 32'(svc_busy_o), 32'd0);
    check({tag, "_svc_count"}, 32'(svc_count_o), 32'd0);
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    int pulses;
    int drop_at;
    bit busy_ok;
    bit done_seen;

    for (int k = 0; k < NP; k++) mem[k] = '0;

    // Reset state.
    #3;
    check_all_zero("reset");
    tick();
    tick();
    prst_n_i = 1'b1;
    tick();

    // Configuration, priorities k+1, zero-wait completer.
    set_prio(0);
    push_cfg(0, 0);
    run_cfg(cyc);
    check("cfg1_cycles", 32'(cyc), 32'(NP * PER_REG));
    check("cfg1_busy_in_done", 32'(cfg_busy_o), 32'd1);
    tick();
    check("cfg1_err", 32'(cfg_err_o), 32'd0);
    check("cfg1_idle_busy", 32'(cfg_busy_o), 32'd0);

    // Service of id 9; valid held one cycle past the pulse.
    push(E_SVC, 9, 1);
    intp_to_service_i = 4'd9;
    intp_valid_i      = 1'b1;
    busy_cnt = 0;
    pulses   = 0;
    drop_at  = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (svc_busy_o) busy_cnt++;
      if (intp_serviced_o) begin
        pulses++;
        if (drop_at < 0) drop_at = i + 2;
      end
      if (i == drop_at) intp_valid_i = 1'b0;
    end
    check("svc_busy_cycles", 32'(busy_cnt), 32'd5);
    check("svc_pulses", 32'(pulses), 32'd1);
    check("svc_id", 32'(svc_id_o), 32'd9);
    check("svc_count", 32'(svc_count_o), 32'd1);

    // Start and interrupt together: service first, then configuration.
    set_prio(1);
    push(E_SVC, 3, 2);
    push_cfg(1, 0);
    intp_to_service_i = 4'd3;
    intp_valid_i      = 1'b1;
    cfg_start_i       = 1'b1;
    tick();
    cfg_start_i = 1'b0;
    busy_ok   = 1'b1;
    done_seen = 1'b0;
    drop_at   = -1;
    for (int i = 0; i < 200 && !done_seen; i++) begin
      if (!cfg_busy_o) busy_ok = 1'b0;
      if (intp_serviced_o && drop_at < 0) drop_at = i + 2;
      if (i == drop_at) intp_valid_i = 1'b0;
      if (cfg_done_o) done_seen = 1'b1;
      else tick();
    end
    check("combo_busy_throughout", 32'(busy_ok), 32'd1);
    check("combo_done_seen", 32'(done_seen), 32'd1);
    tick();

    // Three wait states, error on address 5.
    set_prio(2);
    wait_n   = 3;
    err_addr = 5;
    push_cfg(2, 1);
    run_cfg(cyc);
    check("cfg_wait_cycles", 32'(cyc), 32'(NP * (PER_REG + (PER_REG / 2) * 3)));
    check("cfg_err_set", 32'(cfg_err_o), 32'd1);
    tick();
    check("cfg_err_sticky", 32'(cfg_err_o), 32'd1);
    wait_n   = 0;
    err_addr = -1;

    // Reset during the write access of address 7.
    set_prio(0);
    push_writes(0, 7);
    cfg_start_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
    cyc = 0;
    while (!(penable_o && pwrite_o && paddr_o == 4'd7) && cyc < 100) begin
      tick();
      cyc++;
    end
    check("reach_addr7", 32'(penable_o && paddr_o == 4'd7), 32'd1);
    prst_n_i = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    prst_n_i = 1'b1;
    tick();
    check("partial_xfers_done", 32'(q.size()), 32'd0);
    push_cfg(0, 0);
    run_cfg(cyc);
    check("restart_cycles", 32'(cyc), 32'(NP * PER_REG));
    tick();

`ifdef INTP_SVC_READBACK_EN
    // Corrupted readback of address 3.
    set_prio(2);
    corrupt_addr = 3;
    push_cfg(2, 1);
    run_cfg(cyc);
    check("rb_cycles", 32'(cyc), 32'(NP * 4));
    check("rb_err", 32'(cfg_err_o), 32'd1);
    corrupt_addr = -1;
    tick();
`endif

    repeat (4) tick();
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
